// File: rtl/nfca_seq_pkg.sv
// Shared types and constants for the NFC-A transaction scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nfca_seq_pkg;

  // Core clock in Hz; the default cycle budgets below derive from it.
  localparam int unsigned CLK_HZ = 81_360_000;

  localparam int unsigned DEF_GUARD_CYCLES      = CLK_HZ / 200;  // 5 ms
  localparam int unsigned DEF_RX_TIMEOUT_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_IDLE_OFF_CYCLES   = CLK_HZ;        // 1 s

  typedef enum logic [2:0] {
    S_IDLE,
    S_CARRIER_UP,
    S_TX_KICK,
    S_TX_WAIT,
    S_RX_WAIT,
    S_RESP
  } state_e;

  // Status codes returned to the requester.
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NO_RESP = 2'd1;
  localparam logic [1:0] ST_RX_ERR  = 2'd2;
  localparam logic [1:0] ST_OFF_ACK = 2'd3;

endpackage

// File: rtl/nfca_cycle_timer.sv
// Shared cycle counter for guard time, RX timeout and idle auto-off.
// Latency: expire is combinational on the registered count.
// Backpressure: none; the owner gates run/clear by state.
module nfca_cycle_timer #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          run,
  input  logic [CW-1:0] limit,
  output logic          expire
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority over run.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Limit is the last count value of the interval (length - 1).
  assign expire = run & (cnt_q == limit);

endmodule

// File: rtl/nfca_txn_scheduler.sv
// Runs one NFC-A transaction: carrier up, guard, TX kick, RX window, status.
// Latency: carrier on -> tx_start 1 cycle after accept; carrier off -> 1+GUARD.
// Backpressure: req_ready only in IDLE; status held until rsp_ready.
module nfca_txn_scheduler
  import nfca_seq_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES      = DEF_GUARD_CYCLES,
  parameter int unsigned RX_TIMEOUT_CYCLES = DEF_RX_TIMEOUT_CYCLES,
  parameter int unsigned IDLE_OFF_CYCLES   = DEF_IDLE_OFF_CYCLES,
  parameter int unsigned CW                = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_carrier_off,
  input  logic       req_rx_expect,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       rx_en,
  input  logic       rx_done,
  input  logic       rx_err,
  output logic       carrier_en,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status
);

  state_e        state_q;
  logic          carrier_en_q;
  logic          tx_start_q;
  logic          rx_en_q;
  logic          rsp_valid_q;
  logic [1:0]    rsp_status_q;
  logic          rx_expect_q;

  logic          req_fire;
  logic          tmr_run;
  logic          tmr_clear;
  logic          tmr_expire;
  logic [CW-1:0] tmr_limit;

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign req_fire  = req_valid & req_ready;

  // The timer only runs in the three timed phases; it restarts from 0 on
  // every entry because it is held clear in all other states, on expiry
  // and on request acceptance (an accepted request beats idle auto-off).
  assign tmr_run   = (state_q == S_CARRIER_UP) | (state_q == S_RX_WAIT) |
                     ((state_q == S_IDLE) & carrier_en_q);
  assign tmr_clear = ~tmr_run | tmr_expire | req_fire;

  // Select the interval limit for whichever timed phase is active.
  always_comb begin
    tmr_limit = CW'(IDLE_OFF_CYCLES - 1);
    case (state_q)
      S_CARRIER_UP: tmr_limit = CW'(GUARD_CYCLES - 1);
      S_RX_WAIT:    tmr_limit = CW'(RX_TIMEOUT_CYCLES - 1);
      default:      tmr_limit = CW'(IDLE_OFF_CYCLES - 1);
    endcase
  end

  nfca_cycle_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .run    (tmr_run),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      carrier_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      rx_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rx_expect_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            rx_expect_q <= req_rx_expect;
            if (req_carrier_off) begin
              carrier_en_q <= 1'b0;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OFF_ACK;
              state_q      <= S_RESP;
            end else if (!carrier_en_q) begin
              carrier_en_q <= 1'b1;
              state_q      <= S_CARRIER_UP;
            end else begin
              tx_start_q <= 1'b1;
              state_q    <= S_TX_KICK;
            end
          end else if (tmr_expire) begin
            carrier_en_q <= 1'b0;
          end
        end
        S_CARRIER_UP: begin
          if (tmr_expire) begin
            tx_start_q <= 1'b1;
            state_q    <= S_TX_KICK;
          end
        end
        S_TX_KICK: begin
          state_q <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_done) begin
            if (rx_expect_q) begin
              rx_en_q <= 1'b1;
              state_q <= S_RX_WAIT;
            end else begin
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              state_q      <= S_RESP;
            end
          end
        end
        S_RX_WAIT: begin
          // A frame ending on the timeout cycle still counts as received.
          if (rx_done) begin
            rx_en_q      <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= rx_err ? ST_RX_ERR : ST_OK;
            state_q      <= S_RESP;
          end else if (tmr_expire) begin
            rx_en_q      <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_NO_RESP;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign carrier_en = carrier_en_q;
  assign tx_start   = tx_start_q;
  assign rx_en      = rx_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_nfca_txn_scheduler.sv
// Directed bench for nfca_txn_scheduler with a status scoreboard.
// Stimulus pushes expected statuses; a negedge monitor pops on handshake.
// Timing checks are made #1 after the rising edge.
module tb_nfca_txn_scheduler;
  import nfca_seq_pkg::*;

  localparam int G = 8;
  localparam int R = 20;
  localparam int I = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_carrier_off = 1'b0;
  logic       req_rx_expect = 1'b0;
  logic       tx_start;
  logic       tx_done = 1'b0;
  logic       rx_en;
  logic       rx_done = 1'b0;
  logic       rx_err = 1'b0;
  logic       carrier_en;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_status;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  nfca_txn_scheduler #(
    .GUARD_CYCLES      (G),
    .RX_TIMEOUT_CYCLES (R),
    .IDLE_OFF_CYCLES   (I),
    .CW                (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_carrier_off (req_carrier_off),
    .req_rx_expect   (req_rx_expect),
    .tx_start        (tx_start),
    .tx_done         (tx_done),
    .rx_en           (rx_en),
    .rx_done         (rx_done),
    .rx_err          (rx_err),
    .carrier_en      (carrier_en),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_status      (rsp_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic off, input logic rxe);
    req_valid = 1'b1;
    req_carrier_off = off;
    req_rx_expect = rxe;
    check("req_ready_before_issue", req_ready, 1);
    tick(1);
    req_valid = 1'b0;
    req_carrier_off = 1'b0;
    req_rx_expect = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  // Accept the pending status; returns in the first IDLE cycle.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
  endtask

  // Cold TX-only transaction; returns in the first IDLE cycle afterwards.
  task automatic tx_only_cold(input string tag);
    issue(1'b0, 1'b0);
    check({tag, "_carrier_up"}, carrier_en, 1);
    tick(G);
    check({tag, "_kick"}, tx_start, 1);
    tick(1);
    exp_q.push_back(ST_OK);
    pulse_tx_done();
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    take_rsp();
  endtask

  // Scoreboard monitor: compare status whenever a handshake is presented.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        bad++;
        total++;
        $display("FAIL rsp_unexpected: got status %0d with no expected entry", rsp_status);
      end else begin
        check("rsp_status", rsp_status, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    tick(2);
    check("rst_carrier_en", carrier_en, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_rx_en", rx_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_req_ready_low", req_ready, 0);
    rst = 1'b0;
    #1;
    check("req_ready_after_rst", req_ready, 1);
    tick(1);

    // T1: cold start with RX reply OK; stray rx_done in TX_WAIT ignored.
    issue(1'b0, 1'b1);
    check("t1_carrier_on", carrier_en, 1);
    check("t1_no_kick_yet", tx_start, 0);
    tick(G - 1);
    check("t1_guard_no_kick", tx_start, 0);
    tick(1);
    check("t1_kick", tx_start, 1);
    tick(1);
    check("t1_kick_one_cycle", tx_start, 0);
    rx_done = 1'b1;
    rx_err = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_err = 1'b0;
    tick(1);
    check("t1_stray_rx_ignored", rsp_valid, 0);
    exp_q.push_back(ST_OK);
    pulse_tx_done();
    check("t1_rx_en_on", rx_en, 1);
    tick(8);
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rx_en_off", rx_en, 0);
    take_rsp();

    // T2: warm start, RX timeout, status held while rsp_ready is low.
    issue(1'b0, 1'b1);
    check("t2_kick_next_cycle", tx_start, 1);
    tick(1);
    exp_q.push_back(ST_NO_RESP);
    pulse_tx_done();
    check("t2_rx_en_on", rx_en, 1);
    tick(R - 1);
    check("t2_no_rsp_before_timeout", rsp_valid, 0);
    check("t2_rx_en_still_on", rx_en, 1);
    tick(1);
    check("t2_rsp_at_timeout", rsp_valid, 1);
    check("t2_rx_en_off_at_timeout", rx_en, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_status", rsp_status, ST_NO_RESP);
    end
    take_rsp();
    check("t2_rsp_dropped", rsp_valid, 0);

    // T3: rx_done with rx_err on the timeout cycle wins over the timeout.
    issue(1'b0, 1'b1);
    tick(1);
    exp_q.push_back(ST_RX_ERR);
    pulse_tx_done();
    tick(R - 1);
    rx_done = 1'b1;
    rx_err = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_err = 1'b0;
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_status_rx_err", rsp_status, ST_RX_ERR);
    take_rsp();

    // T4: two carrier-off requests, both acknowledged.
    exp_q.push_back(ST_OFF_ACK);
    issue(1'b1, 1'b0);
    check("t4_carrier_off", carrier_en, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    take_rsp();
    exp_q.push_back(ST_OFF_ACK);
    issue(1'b1, 1'b0);
    check("t4b_carrier_stays_off", carrier_en, 0);
    check("t4b_rsp_valid", rsp_valid, 1);
    take_rsp();

    // T5: idle auto-off after I cycles, then a request on the last idle cycle.
    tx_only_cold("t5a");
    tick(I - 1);
    check("t5_carrier_before_off", carrier_en, 1);
    tick(1);
    check("t5_carrier_auto_off", carrier_en, 0);
    tick(1);
    tx_only_cold("t5b");
    tick(I - 1);
    issue(1'b0, 1'b0);
    check("t5_req_wins_carrier", carrier_en, 1);
    check("t5_req_wins_kick", tx_start, 1);
    tick(1);
    exp_q.push_back(ST_OK);
    pulse_tx_done();
    check("t5_rsp_valid", rsp_valid, 1);
    take_rsp();

    // T6: reset in RX_WAIT aborts silently.
    issue(1'b0, 1'b1);
    tick(1);
    pulse_tx_done();
    tick(3);
    check("t6_in_rx_wait", rx_en, 1);
    rst = 1'b1;
    tick(1);
    check("t6_carrier_en", carrier_en, 0);
    check("t6_rx_en", rx_en, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    check("t6_req_ready_after", req_ready, 1);
    tick(3);
    check("t6_no_rsp_after_abort", rsp_valid, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
